uart_tx_dev: RTL and testbench

- Memory-mapped transmit-only UART peripheral for the simple system bus; sits downstream of the bus as a device beside RAM and timer.
- Software writes characters into a TX FIFO; a serialiser shifts them out LSB first on a single line.
- Provides status readback, a programmable bit-period divider and an optional TX-empty interrupt to the core.

---
 rtl/uart_tx_dev.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - memory-mapped transmit-only UART with TX FIFO and divider
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_dev #(
  parameter int          DataWidth    = 32,
  parameter int          AddressWidth = 32,
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] DivReset     = 16'd867
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    uart_req_i,
  input  logic                    uart_we_i,
  input  logic [3:0]              uart_be_i,
  input  logic [AddressWidth-1:0] uart_addr_i,
  input  logic [DataWidth-1:0]    uart_wdata_i,
  output logic                    uart_rvalid_o,
  output logic [DataWidth-1:0]    uart_rdata_o,
  output logic                    uart_err_o,
  output logic                    uart_tx_o,
  output logic                    uart_intr_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FifoDepth);
`ifdef UART_TX_PARITY_EN
  localparam logic ParEn = 1'b1;
`else
  localparam logic ParEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d, reload_q, reload_d, div_q, div_d;
  logic [7:0]             byte_q, byte_d;
  logic [2:0]             idx_q, idx_d;
  logic                   irq_en_q, irq_en_d;
  logic                   rvalid_q, err_q, err_d, intr_q;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]        level_q;
  logic [7:0]             mem_q [FifoDepth];

  logic [7:0]  off;
  logic        fifo_empty, fifo_full, push_req, push, pop, busy, bit_done;
  logic [31:0] status_w;
  logic        unused_bits;

  assign off        = uart_addr_i[9:2];
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FullLvl);
  assign busy       = (state_q != S_IDLE);
  assign bit_done   = (cnt_q == 16'd0);
  assign push_req   = uart_req_i & uart_we_i & (off == 8'h00) & uart_be_i[0];
  // A push that meets a full FIFO is dropped even if a pop happens the same cycle.
  assign push       = push_req & ~fifo_full;

  assign unused_bits = ^{uart_addr_i[AddressWidth-1:10], uart_addr_i[1:0],
                         uart_wdata_i[DataWidth-1:16], uart_be_i[3:2]};

  always_comb begin
    status_w              = '0;
    status_w[0]           = fifo_empty;
    status_w[1]           = fifo_full;
    status_w[2]           = busy;
    status_w[3]           = ParEn;
    status_w[8 +: LvlW]   = level_q;
  end

  always_comb begin
    rdata_d  = '0;
    err_d    = 1'b0;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    if (uart_req_i) begin
      case (off)
        8'h00: err_d = push_req & fifo_full;
        8'h01: begin
          if (uart_we_i) err_d = 1'b1;
          else           rdata_d = DataWidth'(status_w);
        end
        8'h02: begin
          if (uart_we_i) begin
            if (uart_be_i[0]) div_d[7:0]  = uart_wdata_i[7:0];
            if (uart_be_i[1]) div_d[15:8] = uart_wdata_i[15:8];
          end else begin
            rdata_d = DataWidth'(div_q);
          end
        end
        8'h03: begin
          if (uart_we_i) irq_en_d = uart_wdata_i[0];
          else           rdata_d  = DataWidth'(irq_en_q);
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      intr_q   <= 1'b0;
      div_q    <= DivReset;
      irq_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rvalid_q <= uart_req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      intr_q   <= irq_en_q & fifo_empty & ~busy;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q  <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= uart_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      byte_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    byte_d   = byte_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE:  pop = ~fifo_empty;
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done) begin
          idx_d = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_d = S_STOP;
`endif
      S_STOP: begin
        if (bit_done) begin
          if (fifo_empty) state_d = S_IDLE;
          else            pop     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (busy) cnt_d = bit_done ? reload_q : cnt_q - 16'd1;
    // DIV is sampled only at frame start so mid-frame writes affect the next frame.
    if (pop) begin
      state_d  = S_START;
      byte_d   = mem_q[rd_ptr_q];
      reload_d = div_q;
      cnt_d    = div_q;
      idx_d    = '0;
    end
  end

  always_comb begin
    uart_tx_o = 1'b1;
    case (state_q)
      S_START:  uart_tx_o = 1'b0;
      S_DATA:   uart_tx_o = byte_q[idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: uart_tx_o = ^byte_q;
`endif
      default:  uart_tx_o = 1'b1;
    endcase
  end

  assign uart_rvalid_o = rvalid_q;
  assign uart_rdata_o  = rdata_q;
  assign uart_err_o    = err_q;
  assign uart_intr_o   = intr_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - self-checking bench for uart_tx_dev against a frame-level model
module tb_uart_tx_dev;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;
  localparam logic [31:0] ST_EMPTY = PAR ? 32'h9 : 32'h1;

  logic        clk_i, rst_i, req, we, rvalid, err, tx, intr;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  int          n_tests, n_fail;

  uart_tx_dev #(.FifoDepth(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .uart_req_i(req), .uart_we_i(we), .uart_be_i(be),
    .uart_addr_i(addr), .uart_wdata_i(wdata), .uart_rvalid_o(rvalid), .uart_rdata_o(rdata),
    .uart_err_o(err), .uart_tx_o(tx), .uart_intr_o(intr)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Model: unbounded byte queue plus a countdown of remaining frame clocks.
  logic [7:0]  m_mem [1024];
  int          m_head, m_tail, m_rem, m_fdiv;
  logic [15:0] m_div;
  logic        m_irq;
  logic [10:0] m_frame;
  logic        e_rvalid, e_err, e_intr;
  logic [31:0] e_rdata;

  int          mc_sz;
  logic        mc_busy, mc_er, mc_push, mc_pop, mc_irq_n;
  logic [31:0] mc_status, mc_rd;
  logic [15:0] mc_div_n;
  logic [7:0]  mc_byte;
  logic [10:0] mc_frame_n;

  always_comb begin
    mc_sz     = m_tail - m_head;
    mc_busy   = (m_rem != 0);
    mc_status = 32'(mc_sz == 0) | (32'(mc_sz == DEPTH) << 1) | (32'(mc_busy) << 2)
              | (PAR ? 32'h8 : 32'h0) | (32'(mc_sz) << 8);
    mc_rd = 32'h0; mc_er = 1'b0; mc_push = 1'b0; mc_div_n = m_div; mc_irq_n = m_irq;
    if (req) begin
      case (addr[9:2])
        8'h00: if (we && be[0]) begin
          if (mc_sz == DEPTH) mc_er = 1'b1; else mc_push = 1'b1;
        end
        8'h01: if (we) mc_er = 1'b1; else mc_rd = mc_status;
        8'h02: if (we) begin
          if (be[0]) mc_div_n[7:0]  = wdata[7:0];
          if (be[1]) mc_div_n[15:8] = wdata[15:8];
        end else mc_rd = {16'h0, m_div};
        8'h03: if (we) mc_irq_n = wdata[0]; else mc_rd = {31'h0, m_irq};
        default: mc_er = 1'b1;
      endcase
    end
    mc_pop  = (mc_sz != 0) && (m_rem <= 1);
    mc_byte = m_mem[m_head % 1024];
    mc_frame_n = '1;
    mc_frame_n[0] = 1'b0;
    mc_frame_n[8:1] = mc_byte;
    if (PAR) mc_frame_n[9] = ^mc_byte;
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_head <= 0; m_tail <= 0; m_rem <= 0; m_fdiv <= 0; m_div <= 16'd867; m_irq <= 1'b0;
      m_frame <= '1; e_rvalid <= 1'b0; e_rdata <= 32'h0; e_err <= 1'b0; e_intr <= 1'b0;
    end else begin
      if (mc_pop) begin
        m_frame <= mc_frame_n;
        m_fdiv  <= int'(m_div);
        m_rem   <= NBITS * (int'(m_div) + 1);
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end
      m_head <= m_head + (mc_pop ? 1 : 0);
      if (mc_push) begin
        m_mem[m_tail % 1024] <= wdata[7:0];
        m_tail <= m_tail + 1;
      end
      e_rvalid <= req; e_rdata <= mc_rd; e_err <= mc_er;
      e_intr   <= m_irq && (mc_sz == 0) && !mc_busy;
      m_div    <= mc_div_n; m_irq <= mc_irq_n;
    end
  end

  function automatic logic model_tx();
    int pos;
    if (m_rem == 0) return 1'b1;
    pos = (NBITS * (m_fdiv + 1) - m_rem) / (m_fdiv + 1);
    return m_frame[pos];
  endfunction

  task automatic drive(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic idle_bus();
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; idle_bus();
    repeat (3) @(negedge clk_i);
    n_tests++; if (tx !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || intr !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got tx=%b rv=%b err=%b intr=%b rdata=%h required 1 0 0 0 0", tx, rvalid, err, intr, rdata);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    drive(1'b0, 4'hF, 32'h4, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rvalid !== 1'b1 || rdata !== ST_EMPTY || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got rv=%b rdata=%h err=%b required 1 %h 0", rvalid, rdata, err, ST_EMPTY);
    end
    drive(1'b0, 4'hF, 32'h8, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rdata !== 32'h363 || err !== 1'b0 || tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_div: got rdata=%h err=%b tx=%b required 363 0 1", rdata, err, tx);
    end
    idle_bus();
  endtask

  task automatic test_frame();
    logic [7:0] b;
    logic       exp;
    int         pos;
    drive(1'b1, 4'h3, 32'h8, 32'h3);
    @(negedge clk_i);
    idle_bus();
    @(negedge clk_i);
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h55 : 8'($urandom);
      drive(1'b1, 4'h1, 32'h0, {24'h0, b});
      for (int k = 1; k <= 2 + 4 * NBITS + 3; k++) begin
        @(negedge clk_i);
        if (k == 1) begin
          idle_bus();
          n_tests++; if (err !== 1'b0 || rvalid !== 1'b1) begin
            n_fail++; $display("FAIL frame_wr_resp: got err=%b rv=%b required 0 1", err, rvalid);
          end
        end
        pos = (k - 2) / 4;
        if (k < 2)                   exp = 1'b1;
        else if (pos == 0)           exp = 1'b0;
        else if (pos <= 8)           exp = b[pos-1];
        else if (PAR && pos == 9)    exp = ^b;
        else                         exp = 1'b1;
        n_tests++; if (tx !== exp || tx !== model_tx()) begin
          n_fail++; $display("FAIL frame_tx byte=%h k=%0d: got %b required %b (model %b)", b, k, tx, exp, model_tx());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    drive(1'b1, 4'h3, 32'h8, 32'h0);
    @(negedge clk_i);
    idle_bus();
    for (int i = 0; i < 2000 && (m_rem != 0 || m_tail != m_head); i++) @(negedge clk_i);
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'h1, 32'h0, $urandom);
      @(negedge clk_i);
      if (err === 1'b1) errs++;
      n_tests++; if (rvalid !== e_rvalid || err !== e_err || tx !== model_tx()) begin
        n_fail++; $display("FAIL b2b_push %0d: got rv=%b err=%b tx=%b required %b %b %b", i, rvalid, err, tx, e_rvalid, e_err, model_tx());
      end
    end
    n_tests++; if (errs !== 3) begin
      n_fail++; $display("FAIL b2b_err_count: got %0d required 3", errs);
    end
    for (int i = 0; i < 130; i++) begin
      drive(1'b0, 4'hF, 32'h4, 32'h0);
      @(negedge clk_i);
      n_tests++; if (rdata !== e_rdata || err !== 1'b0 || tx !== model_tx()) begin
        n_fail++; $display("FAIL b2b_drain %0d: got status=%h err=%b tx=%b required %h 0 %b", i, rdata, err, tx, e_rdata, model_tx());
      end
    end
    n_tests++; if (rdata !== ST_EMPTY) begin
      n_fail++; $display("FAIL b2b_final_status: got %h required %h", rdata, ST_EMPTY);
    end
    idle_bus();
  endtask

  task automatic test_irq();
    drive(1'b1, 4'h3, 32'h8, 32'h1);
    @(negedge clk_i);
    drive(1'b1, 4'hF, 32'hC, 32'h1);
    @(negedge clk_i);
    idle_bus();
    @(negedge clk_i);
    n_tests++; if (intr !== 1'b1) begin
      n_fail++; $display("FAIL irq_idle: got %b required 1", intr);
    end
    drive(1'b1, 4'h1, 32'h0, 32'hA3);
    for (int k = 1; k <= 2 + 2 * NBITS + 3; k++) begin
      @(negedge clk_i);
      idle_bus();
      n_tests++; if (intr !== e_intr || (mc_busy && intr !== 1'b0) || tx !== model_tx()) begin
        n_fail++; $display("FAIL irq_frame k=%0d: got intr=%b tx=%b required %b %b", k, intr, tx, e_intr, model_tx());
      end
    end
    n_tests++; if (intr !== 1'b1) begin
      n_fail++; $display("FAIL irq_after_stop: got %b required 1", intr);
    end
    drive(1'b1, 4'hF, 32'hC, 32'h0);
    @(negedge clk_i);
    idle_bus();
    @(negedge clk_i);
    n_tests++; if (intr !== 1'b0) begin
      n_fail++; $display("FAIL irq_disable: got %b required 0", intr);
    end
  endtask

  task automatic test_bad_access();
    drive(1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL bad_read: got rv=%b err=%b rdata=%h required 1 1 0", rvalid, err, rdata);
    end
    drive(1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF);
    @(negedge clk_i);
    n_tests++; if (rvalid !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL status_write: got rv=%b err=%b required 1 1", rvalid, err);
    end
    drive(1'b1, 4'hF, 32'h3FC, 32'h1234_5678);
    @(negedge clk_i);
    n_tests++; if (err !== 1'b1) begin
      n_fail++; $display("FAIL bad_write: got err=%b required 1", err);
    end
    drive(1'b1, 4'hE, 32'h0, 32'h77);
    @(negedge clk_i);
    n_tests++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL tx_be0_low: got err=%b required 0", err);
    end
    drive(1'b0, 4'hF, 32'h4, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rdata !== ST_EMPTY) begin
      n_fail++; $display("FAIL bad_status_kept: got %h required %h", rdata, ST_EMPTY);
    end
    drive(1'b0, 4'hF, 32'h8, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rdata !== 32'h1) begin
      n_fail++; $display("FAIL bad_div_kept: got %h required 1", rdata);
    end
    drive(1'b0, 4'hF, 32'hC, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rdata !== 32'h0) begin
      n_fail++; $display("FAIL bad_irq_kept: got %h required 0", rdata);
    end
    drive(1'b1, 4'h2, 32'h8, 32'h0000_AB00);
    @(negedge clk_i);
    drive(1'b0, 4'hF, 32'h8, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rdata !== 32'hAB01) begin
      n_fail++; $display("FAIL div_be_hi: got %h required ab01", rdata);
    end
    drive(1'b1, 4'h1, 32'h8, 32'hFFFF_FF05);
    @(negedge clk_i);
    drive(1'b0, 4'hF, 32'h8, 32'h0);
    @(negedge clk_i);
    n_tests++; if (rdata !== 32'hAB05) begin
      n_fail++; $display("FAIL div_be_lo: got %h required ab05", rdata);
    end
    drive(1'b1, 4'h3, 32'h8, 32'h3);
    @(negedge clk_i);
    idle_bus();
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    drive(1'b1, 4'h1, 32'h0, {24'h0, 8'($urandom)});
    @(negedge clk_i);
    idle_bus();
    repeat (2) @(negedge clk_i);
    n_tests++; if (tx !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre_start: got %b required 0", tx);
    end
    #2 rst_i = 1'b1;
    #1;
    n_tests++; if (tx !== 1'b1) begin
      n_fail++; $display("FAIL rst_async_start: got %b required 1", tx);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b1, 4'h3, 32'h8, 32'h3);
    @(negedge clk_i);
    drive(1'b1, 4'h1, 32'h0, 32'hFF);
    @(negedge clk_i);
    drive(1'b1, 4'h1, 32'h0, $urandom);
    @(negedge clk_i);
    drive(1'b1, 4'h1, 32'h0, $urandom);
    @(negedge clk_i);
    idle_bus();
    repeat (10) @(negedge clk_i);
    n_tests++; if (tx !== 1'b1 || model_tx() !== 1'b1 || mc_sz !== 2) begin
      n_fail++; $display("FAIL rst_pre_data: got tx=%b required 1 (queued %0d)", tx, mc_sz);
    end
    #2 rst_i = 1'b1;
    #1;
    n_tests++; if (tx !== 1'b1) begin
      n_fail++; $display("FAIL rst_async_data: got %b required 1", tx);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    drive(1'b0, 4'hF, 32'h4, 32'h0);
    @(negedge clk_i);
    idle_bus();
    n_tests++; if (rdata !== ST_EMPTY || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_flush_status: got %h err=%b required %h 0", rdata, err, ST_EMPTY);
    end
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_i);
      if (tx !== 1'b1) lows++;
    end
    n_tests++; if (lows !== 0) begin
      n_fail++; $display("FAIL rst_no_frames: got %0d non-idle cycles required 0", lows);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_i = 1'b1; idle_bus();
    test_reset();
    test_frame();
    test_back_to_back();
    test_irq();
    test_bad_access();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
